// File: rtl/ov5640_sccb_pkg.sv
// Shared types and constants for the OV5640 SCCB write master.
// bus_level maps a bus-sequencer position onto the {scl, sda_oe} pin pair.
package ov5640_sccb_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        BYTE  = 3'd2,
        STOP  = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic [1:0] Q0 = 2'd0;
    localparam logic [1:0] Q1 = 2'd1;
    localparam logic [1:0] Q2 = 2'd2;
    localparam logic [1:0] Q3 = 2'd3;

    localparam int BYTES_PER_WR  = 4;
    localparam int BITS_PER_BYTE = 9;

    localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_WR - 1);
    localparam logic [3:0] ACK_BIT   = 4'(BITS_PER_BYTE - 1);

    localparam logic [6:0] DEFAULT_DEVICE_ADDR = 7'h3C;

    // Returns {scl, sda_oe}; sda_oe=1 pulls the open-drain line low.
    function automatic logic [1:0] bus_level(
        input state_t     st,
        input logic [1:0] ph,
        input logic [3:0] bit_idx,
        input logic       data_bit
    );
        logic [1:0] lv;
        lv = 2'b10;
        case (st)
            START: begin
                case (ph)
                    Q0:      lv = 2'b10;
                    Q1, Q2:  lv = 2'b11;
                    default: lv = 2'b01;
                endcase
            end
            BYTE: begin
                lv = {((ph == Q1) || (ph == Q2)),
                      ((bit_idx == ACK_BIT) ? 1'b0 : ~data_bit)};
            end
            STOP: begin
                case (ph)
                    Q0:      lv = 2'b01;
                    Q1:      lv = 2'b11;
                    default: lv = 2'b10;
                endcase
            end
            default: lv = 2'b10;
        endcase
        return lv;
    endfunction

endpackage

// File: rtl/sccb_qtick.sv
// Quarter-SCL-period timebase: counts 0..DIV-1 while enabled and advances
// a 2-bit phase on every wrap; a clear restarts both at zero.
module sccb_qtick
    import ov5640_sccb_pkg::*;
#(
    parameter int DIV = 50
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_clr,
    input  logic       i_en,
    output logic       o_tick,
    output logic       o_first,
    output logic [1:0] o_phase
);

    localparam int             CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0]  LAST = CW'(DIV - 1);

    logic [CW-1:0] r_cnt;
    logic [1:0]    r_phase;

    // Divider counter and quarter phase
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt   <= '0;
            r_phase <= Q0;
        end else if (i_clr) begin
            r_cnt   <= '0;
            r_phase <= Q0;
        end else if (i_en) begin
            if (r_cnt == LAST) begin
                r_cnt   <= '0;
                r_phase <= r_phase + 2'd1;
            end else begin
                r_cnt   <= r_cnt + CW'(1);
            end
        end else begin
            r_cnt   <= r_cnt;
            r_phase <= r_phase;
        end
    end

    assign o_tick  = i_en && (r_cnt == LAST);
    assign o_first = i_en && (r_cnt == '0);
    assign o_phase = r_phase;

endmodule

// File: rtl/ov5640_sccb_wr.sv
// SCCB write master: turns one {reg_addr, reg_val} word into a
// START / 4 bytes / STOP sequence on an open-drain SDA and push-pull SCL.
module ov5640_sccb_wr
    import ov5640_sccb_pkg::*;
#(
    parameter logic [6:0] DEVICE_ADDR  = DEFAULT_DEVICE_ADDR,
    parameter int         SYS_CLK_FREQ = 50_000_000,
    parameter int         SCL_FREQ     = 250_000
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        cfg_start,
    input  logic [23:0] cfg_data,
    output logic        cfg_end,
    output logic        busy,
    output logic        ack_err,
    output logic        scl,
    output logic        sda_oe,
    input  logic        sda_in
);

    localparam int DIV = SYS_CLK_FREQ / (SCL_FREQ * 4);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_bit;
    logic [3:0]  w_bit_nxt;
    logic [1:0]  r_byte;
    logic [1:0]  w_byte_nxt;
    logic [31:0] r_shift;
    logic [31:0] w_shift_nxt;

    logic        w_accept;
    logic        w_run;
    logic        w_tick;
    logic        w_first;
    logic        w_q_end;
    logic        w_ack_sample;
    logic [1:0]  w_phase;
    logic [1:0]  w_phase_nxt;
    logic [1:0]  w_level;

    logic        r_scl;
    logic        r_sda_oe;
    logic        r_busy;
    logic        r_cfg_end;
    logic        r_ack_err;

    assign w_accept = (r_state == IDLE) && cfg_start;
    assign w_run    = (r_state == START) || (r_state == BYTE) || (r_state == STOP);
    assign w_q_end  = w_tick && (w_phase == Q3);

    // ACK is sampled once, on the first sys_clk of Q2 of the ninth bit
    assign w_ack_sample = (r_state == BYTE) && (r_bit == ACK_BIT) &&
                          (w_phase == Q2) && w_first;

    sccb_qtick #(
        .DIV (DIV)
    ) u_qtick (
        .i_clk   (sys_clk),
        .i_rst_n (sys_rst_n),
        .i_clr   (w_accept),
        .i_en    (w_run),
        .o_tick  (w_tick),
        .o_first (w_first),
        .o_phase (w_phase)
    );

    // Phase the timebase will hold after this edge
    always_comb begin
        w_phase_nxt = w_phase;
        if (w_accept) begin
            w_phase_nxt = Q0;
        end else if (w_tick) begin
            w_phase_nxt = w_phase + 2'd1;
        end else begin
            w_phase_nxt = w_phase;
        end
    end

    // Sequencer next-state, bit/byte position and data shifter
    always_comb begin
        w_state_nxt = r_state;
        w_bit_nxt   = r_bit;
        w_byte_nxt  = r_byte;
        w_shift_nxt = r_shift;
        case (r_state)
            IDLE: begin
                if (cfg_start) begin
                    w_state_nxt = START;
                    w_bit_nxt   = 4'd0;
                    w_byte_nxt  = 2'd0;
                    w_shift_nxt = {DEVICE_ADDR, 1'b0, cfg_data};
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            START: begin
                if (w_q_end) begin
                    w_state_nxt = BYTE;
                    w_bit_nxt   = 4'd0;
                    w_byte_nxt  = 2'd0;
                end else begin
                    w_state_nxt = START;
                end
            end
            BYTE: begin
                if (w_q_end) begin
                    if (r_bit == ACK_BIT) begin
                        w_bit_nxt = 4'd0;
                        if (r_byte == LAST_BYTE) begin
                            w_state_nxt = STOP;
                        end else begin
                            w_byte_nxt  = r_byte + 2'd1;
                        end
                    end else begin
                        // The ACK slot carries no data, so only data bits shift
                        w_bit_nxt   = r_bit + 4'd1;
                        w_shift_nxt = {r_shift[30:0], 1'b0};
                    end
                end else begin
                    w_state_nxt = BYTE;
                end
            end
            STOP: begin
                if (w_q_end) begin
                    w_state_nxt = DONE;
                end else begin
                    w_state_nxt = STOP;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Pin levels come from the post-edge position so they land exactly on quarter boundaries
    assign w_level = bus_level(w_state_nxt, w_phase_nxt, w_bit_nxt, w_shift_nxt[31]);

    // Sequencer state register
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state <= IDLE;
            r_bit   <= 4'd0;
            r_byte  <= 2'd0;
            r_shift <= 32'd0;
        end else begin
            r_state <= w_state_nxt;
            r_bit   <= w_bit_nxt;
            r_byte  <= w_byte_nxt;
            r_shift <= w_shift_nxt;
        end
    end

    // Registered pins and handshake/status flags
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_scl     <= 1'b1;
            r_sda_oe  <= 1'b0;
            r_busy    <= 1'b0;
            r_cfg_end <= 1'b0;
            r_ack_err <= 1'b0;
        end else begin
            r_scl     <= w_level[1];
            r_sda_oe  <= w_level[0];
            r_cfg_end <= (r_state == DONE);
            if (w_accept) begin
                r_busy <= 1'b1;
            end else if (r_state == DONE) begin
                r_busy <= 1'b0;
            end else begin
                r_busy <= r_busy;
            end
            if (w_accept) begin
                r_ack_err <= 1'b0;
            end else if (w_ack_sample && sda_in) begin
                r_ack_err <= 1'b1;
            end else begin
                r_ack_err <= r_ack_err;
            end
        end
    end

    assign scl     = r_scl;
    assign sda_oe  = r_sda_oe;
    assign busy    = r_busy;
    assign cfg_end = r_cfg_end;
    assign ack_err = r_ack_err;

endmodule

// File: doc/ov5640_sccb_wr.md
Name: ov5640_sccb_wr

Overview:
SCCB (I2C-compatible) write master for the OV5640 camera. It sits at the other end of the cfg_start / cfg_data / cfg_end handshake used by the register-configuration sequencer. Each accepted 24-bit word {reg_addr[15:0], reg_val[7:0]} becomes one 3-phase SCCB write on SCL/SDA. SDA is open-drain: the block only drives low or releases.

Parameters:
DEVICE_ADDR, 7'h3C, 7-bit SCCB slave address; write byte is {DEVICE_ADDR,1'b0} = 8'h78.
SYS_CLK_FREQ, 50_000_000, sys_clk frequency in Hz.
SCL_FREQ, 250_000, SCL frequency in Hz.
DIV (localparam), SYS_CLK_FREQ/(SCL_FREQ*4), sys_clk cycles per quarter SCL period (default 50); must be >= 2.

Ports:
sys_clk    in   1   system clock
sys_rst_n  in   1   asynchronous active-low reset
cfg_start  in   1   one-cycle request; sampled only while idle
cfg_data   in   24  {reg_addr[15:0], reg_val[7:0]}; latched on acceptance
cfg_end    out  1   one-cycle pulse, transaction complete
busy       out  1   high from acceptance until cfg_end
ack_err    out  1   a NACK was seen in the last transaction
scl        out  1   SCCB clock (push-pull)
sda_oe     out  1   1 = pull SDA low, 0 = release
sda_in     in   1   SDA pad input

Behaviour:
- Reset values: scl=1, sda_oe=0 (bus idle), cfg_end=0, busy=0, ack_err=0, state=IDLE, counters=0.
- Reset asserted mid-transfer: the bus returns immediately to idle levels. No STOP is generated, and no cfg_end is issued.
- Quarter tick: counter 0..DIV-1 runs only while busy and clears on acceptance. A tick occurs at DIV-1.
- Acceptance: in IDLE with cfg_start=1, the block latches cfg_data into shift regs, sets busy=1, clears ack_err, and enters START.
- cfg_start while busy is ignored. No queueing.
- States: IDLE -> START -> BYTE (4 bytes: 8'h78, addr_hi, addr_lo, val) -> STOP -> DONE -> IDLE.
- START: 4 quarters. Q0: scl=1, sda released. Q1: sda low. Q2: sda low. Q3: scl=0.
- BYTE: 9 bits, each 4 quarters, MSB first.
  - Q0: scl=0, set SDA (sda_oe = ~bit).
  - Q1 and Q2: scl=1.
  - Q3: scl=0.
- Bit 9 (ACK slot): SDA is released and sda_in is sampled at the start of Q2. sda_in=1 sets ack_err=1.
- A NACK does not abort the transfer, because the SCCB 9th bit is don't-care.
- STOP: 4 quarters. Q0: scl=0, sda low. Q1: scl=1. Q2: sda released. Q3: hold.
- Total length is 152 quarters = 152*DIV sys_clk cycles.
- DONE: cfg_end=1 for exactly one cycle, in the cycle after the last STOP quarter ends. busy falls in the same cycle, and the state returns to IDLE.
- cfg_end therefore first reads high 152*DIV+1 cycles after the cfg_start sampling edge.
- cfg_start in the cycle after cfg_end (back-to-back) is accepted. The gap between transactions is 1 cycle of bus idle.
- ack_err holds its value until the next acceptance.
- Bit counter is 0..8; byte counter is 0..3. Both wrap only via state change, never mid-byte.

Decomposition:
- Package ov5640_sccb_pkg holds:
  - state enum {IDLE, START, BYTE, STOP, DONE}
  - quarter-phase constants Q0..Q3
  - BYTES_PER_WR = 4, BITS_PER_BYTE = 9
  - default DEVICE_ADDR
- Sub-module sccb_qtick: parameterised DIV counter with clear input, producing the quarter tick and 2-bit phase.

Test Plan:
- SYS_CLK_FREQ=16_000_000, SCL_FREQ=1_000_000 (DIV=4); cfg_data=24'h3008_82 with slave ACKing -> bus decodes START, 8'h78, 8'h30, 8'h08, 8'h82, STOP. cfg_end pulses 609 cycles after cfg_start, ack_err=0.
- Same write, slave NACKs the addr_lo byte -> all four bytes and STOP still appear, ack_err=1 after the third ACK slot, cfg_end still pulses. The next accepted cfg_start clears ack_err to 0.
- cfg_start re-pulsed at cycles 10 and 300 during a transfer -> ignored, exactly one transaction on the bus, one cfg_end.
- sys_rst_n low at cycle 200 (mid addr_hi) -> scl=1, sda_oe=0, busy=0, cfg_end=0 immediately. After release, a fresh write of 24'h3103_11 completes normally.
- Three back-to-back writes, each cfg_start issued the cycle after cfg_end (24'h3103_11, 24'h3008_82, 24'h3008_42) -> three complete transactions, 1-cycle idle gap, three cfg_end pulses, correct bytes each time.
- START/STOP timing check -> SDA changes only while scl=0, except the START falling edge and STOP rising edge, which occur with scl=1.
